muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the EX stage, alongside the ALU.
- Consumes the same forwarded op1/op2 operands as the ALU.
- Its result feeds the EX result mux ahead of the EX/MEM register.
- Holds the pipeline through `busy` until the result is ready, giving RV32M support without a combinational multiplier or divider.

---
 rtl/muldiv_unit_pkg.sv | 32 +++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encodings and operand-sign helpers.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic logic is_div(input md_op_e o);
    return o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op1_signed(input md_op_e o);
    return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op2_signed(input md_op_e o);
    return o inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide share one 2*XLEN accumulator, one bit per cycle, stalling via busy.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  md_op_e            op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  md_op_e            op_in;
  logic              s1, s2, accept, div0, ovf, special;
  logic [XLEN-1:0]   mag1, mag2, special_res;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   quot, rem, fin_res;

  // Accept-time operand conditioning and special-case detection
  always_comb begin
    op_in   = md_op_e'(op);
    s1      = op1_signed(op_in) & op1[XLEN-1];
    s2      = op2_signed(op_in) & op2[XLEN-1];
    mag1    = s1 ? -op1 : op1;
    mag2    = s2 ? -op2 : op2;
    div0    = (op2 == '0);
    ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) && (op1 == MIN_NEG) && (op2 == '1);
    special = is_div(op_in) && (div0 || ovf);
    if ((op_in == OP_DIV) || (op_in == OP_DIVU)) begin
      special_res = div0 ? '1 : MIN_NEG;
    end else begin
      special_res = div0 ? op1 : '0;
    end
    // done_q still high means FIN->IDLE just happened; that cycle must not accept
    accept  = start & ~flush & ~done_q & (state_q == ST_IDLE);
  end

  // Multiply keeps the multiplier in acc[XLEN-1:0] and shifts the product in from the top;
  // divide keeps the partial remainder in acc[2XLEN-1:XLEN] and shifts quotient bits in at the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod      = neg_q  ? -acc_q : acc_q;
    quot      = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem       = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                      fin_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fin_res = quot;
      default:                     fin_res = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d    = op_in;
            neg_d   = s1 ^ s2;
            rneg_d  = s1;
            count_d = '0;
            if (is_div(op_in)) begin
              opnd_d = mag2;
              acc_d  = {{XLEN{1'b0}}, mag1};
            end else begin
              opnd_d = mag1;
              acc_d  = {{XLEN{1'b0}}, mag2};
            end
            // Special cases land in FIN with done already raised; FIN then just retires
            if (special) begin
              state_d  = ST_FIN;
              result_d = special_res;
              done_d   = 1'b1;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_d   = is_div(op_q) ? div_next : mul_next;
          count_d = count_q + 1'b1;
          if (count_q == CW'(XLEN-1)) state_d = ST_FIN;
        end
        ST_FIN: begin
          state_d = ST_IDLE;
          if (!done_q) begin
            result_d = fin_res;
            done_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      opnd_q   <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE) | done_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
